vx_execute_splitter: RTL

- Producer (master side) of the execute handshake: takes one full-warp operand packet from dispatch and emits it as a sequence of NUM_LANES-wide execute packets tagged pid/sop/eop.
- Sits between operand collection and any functional unit narrower than `NUM_THREADS.
- Registered output, valid/ready handshake on both sides; holds one warp in flight.

---
 rtl/vx_execute_splitter_if.sv | 76 +++++++
 rtl/vx_execute_splitter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vx_execute_splitter_if.sv
// rtl/vx_execute_splitter_if.sv - dispatch-side warp request and execute-side packet bundle.
// Build-time widths fall back to the defaults below when the surrounding build does not supply them.
`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 16
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef PC_BITS
`define PC_BITS 32
`endif
`ifndef INST_ALU_BITS
`define INST_ALU_BITS 4
`endif
`ifndef OP_ARGS_BITS
`define OP_ARGS_BITS 8
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif
`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

interface vx_execute_splitter_if #(
   parameter int NUM_LANES  = 4,
   parameter int PID_WIDTH  = `LOG2UP(`NUM_THREADS / NUM_LANES),
   parameter int INFL_WIS_W = 4
);
   localparam int NT_WIDTH = `LOG2UP(`NUM_THREADS);
   // out_data, MSB first: uuid, wid, tmask, PC, op_type, op_args, wb, rd, infl_id,
   // rs1, rs2, rs3 (lane 0 lowest), tid, pid, sop, eop
   localparam int DATA_W = `UUID_WIDTH + `NW_WIDTH + NUM_LANES + `PC_BITS + `INST_ALU_BITS
                         + `OP_ARGS_BITS + 1 + `NR_BITS + INFL_WIS_W + 3 * NUM_LANES * `XLEN
                         + NT_WIDTH + PID_WIDTH + 2;

   logic                             in_valid;
   logic                             in_ready;
   logic [`UUID_WIDTH-1:0]           in_uuid;
   logic [`NW_WIDTH-1:0]             in_wid;
   logic [`NUM_THREADS-1:0]          in_tmask;
   logic [`PC_BITS-1:0]              in_PC;
   logic [`INST_ALU_BITS-1:0]        in_op_type;
   logic [`OP_ARGS_BITS-1:0]         in_op_args;
   logic                             in_wb;
   logic [`NR_BITS-1:0]              in_rd;
   logic [INFL_WIS_W-1:0]            in_infl_id;
   logic [`NUM_THREADS*`XLEN-1:0]    in_rs1_data;
   logic [`NUM_THREADS*`XLEN-1:0]    in_rs2_data;
   logic [`NUM_THREADS*`XLEN-1:0]    in_rs3_data;
   logic                             out_valid;
   logic [DATA_W-1:0]                out_data;
   logic                             out_ready;

   modport master (
      input  in_valid, in_uuid, in_wid, in_tmask, in_PC, in_op_type, in_op_args,
             in_wb, in_rd, in_infl_id, in_rs1_data, in_rs2_data, in_rs3_data,
      output in_ready,
      output out_valid, out_data,
      input  out_ready
   );

   modport slave (
      output in_valid, in_uuid, in_wid, in_tmask, in_PC, in_op_type, in_op_args,
             in_wb, in_rd, in_infl_id, in_rs1_data, in_rs2_data, in_rs3_data,
      input  in_ready,
      input  out_valid, out_data,
      output out_ready
   );
endinterface

// File: rtl/vx_execute_splitter.sv
// rtl/vx_execute_splitter.sv - splits one full-warp operand packet into NUM_LANES-wide execute packets.
// Define VX_EXEC_SKIP_EMPTY_EN to drop lane groups whose thread mask slice is empty.
module vx_execute_splitter #(
   parameter int NUM_LANES  = 4,
   parameter int PID_WIDTH  = `LOG2UP(`NUM_THREADS / NUM_LANES),
   parameter int INFL_WIS_W = 4
) (
   input logic                  clk,
   input logic                  reset,
   vx_execute_splitter_if.master exe_if
);
   localparam int BATCHES  = `NUM_THREADS / NUM_LANES;
   localparam int NT_WIDTH = `LOG2UP(`NUM_THREADS);
   localparam int LANE_DW  = NUM_LANES * `XLEN;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                        state, state_n;
   logic [PID_WIDTH-1:0]          pid, pid_n, first_pid, next_pid;
   logic                          sop, sop_n;
   logic                          eop, load, busy, in_fire, out_fire;
   logic [NT_WIDTH-1:0]           tid_in;

   logic [`UUID_WIDTH-1:0]        uuid_r;
   logic [`NW_WIDTH-1:0]          wid_r;
   logic [`NUM_THREADS-1:0]       tmask_r;
   logic [`PC_BITS-1:0]           pc_r;
   logic [`INST_ALU_BITS-1:0]     op_type_r;
   logic [`OP_ARGS_BITS-1:0]      op_args_r;
   logic                          wb_r;
   logic [`NR_BITS-1:0]           rd_r;
   logic [INFL_WIS_W-1:0]         infl_r;
   logic [`NUM_THREADS*`XLEN-1:0] rs1_r, rs2_r, rs3_r;
   logic [NT_WIDTH-1:0]           tid_r;

   assign busy     = (state == SEND);
   assign exe_if.in_ready  = !busy || (busy && exe_if.out_ready && eop);
   assign in_fire  = exe_if.in_valid && exe_if.in_ready;
   assign out_fire = busy && exe_if.out_ready;

   always_comb begin
      tid_in = '0;
      for (int i = `NUM_THREADS - 1; i >= 0; i--) begin
         if (exe_if.in_tmask[i]) tid_in = NT_WIDTH'(i);
      end
   end

   // first_pid: group loaded on capture; next_pid/eop: successor of the packet on the bus
   always_comb begin
      first_pid = '0;
      next_pid  = pid;
      eop       = 1'b1;
`ifdef VX_EXEC_SKIP_EMPTY_EN
      for (int k = BATCHES - 1; k >= 0; k--) begin
         if (|exe_if.in_tmask[k*NUM_LANES +: NUM_LANES]) first_pid = PID_WIDTH'(k);
      end
      for (int k = BATCHES - 1; k >= 0; k--) begin
         if (k > int'(pid) && (|tmask_r[k*NUM_LANES +: NUM_LANES])) begin
            next_pid = PID_WIDTH'(k);
            eop      = 1'b0;
         end
      end
`else
      next_pid = pid + 1'b1;
      eop      = (int'(pid) == BATCHES - 1);
`endif
   end

   always_comb begin
      state_n = state;
      pid_n   = pid;
      sop_n   = sop;
      load    = 1'b0;
      if (in_fire) begin
         state_n = SEND;
         pid_n   = first_pid;
         sop_n   = 1'b1;
         load    = 1'b1;
      end else if (out_fire) begin
         if (eop) begin
            state_n = IDLE;
         end else begin
            pid_n = next_pid;
            sop_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pid   <= '0;
         sop   <= 1'b0;
      end else begin
         state <= state_n;
         pid   <= pid_n;
         sop   <= sop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         uuid_r    <= '0;
         wid_r     <= '0;
         tmask_r   <= '0;
         pc_r      <= '0;
         op_type_r <= '0;
         op_args_r <= '0;
         wb_r      <= 1'b0;
         rd_r      <= '0;
         infl_r    <= '0;
         rs1_r     <= '0;
         rs2_r     <= '0;
         rs3_r     <= '0;
         tid_r     <= '0;
      end else if (load) begin
         uuid_r    <= exe_if.in_uuid;
         wid_r     <= exe_if.in_wid;
         tmask_r   <= exe_if.in_tmask;
         pc_r      <= exe_if.in_PC;
         op_type_r <= exe_if.in_op_type;
         op_args_r <= exe_if.in_op_args;
         wb_r      <= exe_if.in_wb;
         rd_r      <= exe_if.in_rd;
         infl_r    <= exe_if.in_infl_id;
         rs1_r     <= exe_if.in_rs1_data;
         rs2_r     <= exe_if.in_rs2_data;
         rs3_r     <= exe_if.in_rs3_data;
         tid_r     <= tid_in;
      end
   end

   // Packet fields are slices of registered state only; eop is masked so idle output reads as zero
   assign exe_if.out_valid = busy;
   assign exe_if.out_data  = {uuid_r, wid_r,
                              tmask_r[int'(pid)*NUM_LANES +: NUM_LANES],
                              pc_r, op_type_r, op_args_r, wb_r, rd_r, infl_r,
                              rs1_r[int'(pid)*LANE_DW +: LANE_DW],
                              rs2_r[int'(pid)*LANE_DW +: LANE_DW],
                              rs3_r[int'(pid)*LANE_DW +: LANE_DW],
                              tid_r, pid, sop, eop & busy};
endmodule
